// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the memory responder: FSM states,
// command encoding and the read-burst length decode.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // burst_len is encoded as "beats minus one"; return the real beat count.
  function automatic logic [2:0] burst_beats(input logic [1:0] len);
    return {1'b0, len} + 3'd1;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Local byte store: one synchronous write port and one combinational
// read port, both addressed by a window offset.
module mem_byte_array #(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [7:0]         wdata,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [7:0]         rdata
);

  logic [7:0] mem [0:(1<<DEPTH_W)-1];

  // Contents survive reset, so the write port has no reset term.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts a latched read/write request, waits a
// fixed number of cycles, then writes one byte or streams a 1..4 byte
// read burst that wraps inside the local window. Out-of-window requests
// complete with err after the same delay as a hit.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int                ADDR_W      = 20,
  parameter int                DEPTH_W     = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              RD_WR,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        burst_len,
  input  logic [7:0]        wdata,
  output logic              busy,
  output logic [7:0]        rdata,
  output logic              rvalid,
  output logic              drive_en,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t             state;
  state_t             state_next;

  logic               cmd_q;
  logic [DEPTH_W-1:0] off_q;
  logic [1:0]         len_q;
  logic [7:0]         wdata_q;
  logic               hit_q;

  logic [3:0]         wait_cnt;
  logic [1:0]         beat_cnt;

  logic               accept;
  logic               hit_in;
  logic               last_beat;
  logic               xfer_rd;
  logic               mem_we;
  logic [DEPTH_W-1:0] raddr;
  logic [7:0]         mem_rdata;

  assign accept    = (state == IDLE) && req;
  assign hit_in    = (addr[ADDR_W-1:DEPTH_W] == BASE_ADDR[ADDR_W-1:DEPTH_W]);
  assign last_beat = (({1'b0, beat_cnt} + 3'd1) == burst_beats(len_q));
  assign xfer_rd   = (state == XFER) && hit_q && (cmd_q == CMD_READ);
  // Not gated by reset: a write already in XFER still lands at that edge.
  assign mem_we    = (state == XFER) && hit_q && (cmd_q == CMD_WRITE);
  // Offset sum is DEPTH_W bits wide, so bursts wrap inside the window.
  assign raddr     = off_q + DEPTH_W'(beat_cnt);

  mem_byte_array #(
    .DEPTH_W(DEPTH_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (off_q),
    .wdata (wdata_q),
    .raddr (raddr),
    .rdata (mem_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; misses and writes leave XFER after one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = (WAIT_STATES > 0) ? WAIT : XFER;
        end
      end
      WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (!hit_q || (cmd_q == CMD_WRITE) || last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch and wait/beat counters; inputs only matter at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q    <= CMD_READ;
      off_q    <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      hit_q    <= 1'b0;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (accept) begin
        cmd_q    <= RD_WR;
        off_q    <= addr[DEPTH_W-1:0];
        len_q    <= burst_len;
        wdata_q  <= wdata;
        hit_q    <= hit_in;
        wait_cnt <= WAIT_INIT;
        beat_cnt <= '0;
      end else begin
        if ((state == WAIT) && (wait_cnt != 4'd0)) begin
          wait_cnt <= wait_cnt - 4'd1;
        end
        if (xfer_rd) begin
          beat_cnt <= beat_cnt + 2'd1;
        end
      end
    end
  end

  // Registered bus outputs; rdata holds its last byte between beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= 8'h00;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      busy   <= (state != IDLE);
      rvalid <= xfer_rd;
      done   <= (state == DONE);
      err    <= (state == DONE) && !hit_q;
      if (xfer_rd) begin
        rdata <= mem_rdata;
      end
    end
  end

  assign drive_en = rvalid;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// one with none, driven by the same request inputs.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        rd_wr;
  logic [19:0] addr;
  logic [1:0]  burst_len;
  logic [7:0]  wdata;

  logic        busy2, rvalid2, de2, done2, err2;
  logic [7:0]  rdata2;
  logic        busy0, rvalid0, de0, done0, err0;
  logic [7:0]  rdata0;

  logic        sel0 = 1'b0;
  logic        obs_busy, obs_rvalid, obs_de, obs_done, obs_err;
  logic [7:0]  obs_rdata;

  int          checks = 0;
  int          errors = 0;

  logic [7:0]  rd_bytes [4];
  int          n_beats, first_rv, done_at;
  logic        err_seen, busy_first, de_ok;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_W(20), .DEPTH_W(10), .BASE_ADDR(20'h00000), .WAIT_STATES(2)
  ) u_ws2 (
    .clk(clk), .reset(reset), .req(req), .RD_WR(rd_wr), .addr(addr),
    .burst_len(burst_len), .wdata(wdata), .busy(busy2), .rdata(rdata2),
    .rvalid(rvalid2), .drive_en(de2), .done(done2), .err(err2)
  );

  mem_responder #(
    .ADDR_W(20), .DEPTH_W(10), .BASE_ADDR(20'h00000), .WAIT_STATES(0)
  ) u_ws0 (
    .clk(clk), .reset(reset), .req(req), .RD_WR(rd_wr), .addr(addr),
    .burst_len(burst_len), .wdata(wdata), .busy(busy0), .rdata(rdata0),
    .rvalid(rvalid0), .drive_en(de0), .done(done0), .err(err0)
  );

  assign obs_busy   = sel0 ? busy0   : busy2;
  assign obs_rvalid = sel0 ? rvalid0 : rvalid2;
  assign obs_de     = sel0 ? de0     : de2;
  assign obs_done   = sel0 ? done0   : done2;
  assign obs_err    = sel0 ? err0    : err2;
  assign obs_rdata  = sel0 ? rdata0  : rdata2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request (accepted at edge k), scramble the inputs, then
  // record beats and the done cycle as offsets n from edge k.
  task automatic run_req(input logic wr, input logic [19:0] a,
                         input logic [1:0] len, input logic [7:0] wd);
    n_beats = 0; first_rv = -1; done_at = -1;
    err_seen = 1'b0; busy_first = 1'b0; de_ok = 1'b1;
    @(negedge clk);
    req = 1'b1; rd_wr = wr; addr = a; burst_len = len; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; rd_wr = ~wr; addr = 20'hFFFFF; burst_len = ~len; wdata = ~wd;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) busy_first = obs_busy;
      if (obs_de !== obs_rvalid) de_ok = 1'b0;
      if (obs_rvalid === 1'b1) begin
        if (first_rv < 0) first_rv = n;
        if (n_beats < 4) rd_bytes[n_beats] = obs_rdata;
        n_beats++;
      end
      if (obs_done === 1'b1) begin
        done_at = n;
        err_seen = obs_err;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int cnt;
    int extra;
    reset = 1'b1; req = 1'b0; rd_wr = 1'b0; addr = '0; burst_len = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   obs_busy,   1'b0);
    check("rst_rvalid", obs_rvalid, 1'b0);
    check("rst_de",     obs_de,     1'b0);
    check("rst_done",   obs_done,   1'b0);
    check("rst_err",    obs_err,    1'b0);
    check("rst_rdata",  obs_rdata,  8'h00);
    check("rst_rdata0", rdata0,     8'h00);
    reset = 1'b0;

    // Write then single-byte read.
    run_req(1'b1, 20'h00010, 2'd0, 8'hA5);
    check("wr_done_at", done_at, 4);
    check("wr_err",     err_seen, 1'b0);
    check("wr_beats",   n_beats, 0);
    run_req(1'b0, 20'h00010, 2'd0, 8'h00);
    check("rd1_busy",     busy_first, 1'b1);
    check("rd1_first_rv", first_rv, 3);
    check("rd1_done_at",  done_at, 4);
    check("rd1_err",      err_seen, 1'b0);
    check("rd1_beats",    n_beats, 1);
    check("rd1_data",     rd_bytes[0], 8'hA5);
    @(posedge clk);
    @(negedge clk);
    check("rd1_busy_after", obs_busy, 1'b0);

    // 4-byte burst.
    run_req(1'b1, 20'h00100, 2'd0, 8'h11);
    run_req(1'b1, 20'h00101, 2'd0, 8'h22);
    run_req(1'b1, 20'h00102, 2'd0, 8'h33);
    run_req(1'b1, 20'h00103, 2'd0, 8'h44);
    run_req(1'b0, 20'h00100, 2'd3, 8'h00);
    check("b4_beats",    n_beats, 4);
    check("b4_first_rv", first_rv, 3);
    check("b4_done_at",  done_at, 7);
    check("b4_de",       de_ok, 1'b1);
    check("b4_d0", rd_bytes[0], 8'h11);
    check("b4_d1", rd_bytes[1], 8'h22);
    check("b4_d2", rd_bytes[2], 8'h33);
    check("b4_d3", rd_bytes[3], 8'h44);

    // Burst wraps from the top of the window to offset 0.
    run_req(1'b1, 20'h003FE, 2'd0, 8'h5A);
    run_req(1'b1, 20'h003FF, 2'd0, 8'h6B);
    run_req(1'b1, 20'h00000, 2'd0, 8'h7C);
    run_req(1'b0, 20'h003FE, 2'd2, 8'h00);
    check("wrap_beats", n_beats, 3);
    check("wrap_d0", rd_bytes[0], 8'h5A);
    check("wrap_d1", rd_bytes[1], 8'h6B);
    check("wrap_d2", rd_bytes[2], 8'h7C);

    // Out-of-window read and write.
    run_req(1'b0, 20'h40000, 2'd0, 8'h00);
    check("miss_beats",   n_beats, 0);
    check("miss_done_at", done_at, 4);
    check("miss_err",     err_seen, 1'b1);
    run_req(1'b1, 20'h40000, 2'd0, 8'hEE);
    check("missw_err", err_seen, 1'b1);
    run_req(1'b0, 20'h00000, 2'd0, 8'h00);
    check("missw_keep", rd_bytes[0], 8'h7C);
    check("hit_err_clr", err_seen, 1'b0);

    // A write request pulsed while busy must be ignored.
    @(negedge clk);
    req = 1'b1; rd_wr = 1'b0; addr = 20'h00010; burst_len = 2'd0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b1; rd_wr = 1'b1; wdata = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; rd_wr = 1'b0;
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (obs_done === 1'b1) begin
        cnt = 1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("ign_done_seen", cnt, 1);
    extra = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (obs_busy !== 1'b0) extra++;
    end
    check("ign_no_extra", extra, 0);
    run_req(1'b0, 20'h00010, 2'd0, 8'h00);
    check("ign_data", rd_bytes[0], 8'hA5);

    // Reset during the second beat of a 4-byte burst.
    @(negedge clk);
    req = 1'b1; rd_wr = 1'b0; addr = 20'h00100; burst_len = 2'd3;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (obs_rvalid === 1'b1) cnt++;
      if (cnt == 2) break;
    end
    check("rstb_beats", cnt, 2);
    check("rstb_d1", obs_rdata, 8'h22);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rstb_busy",   obs_busy,   1'b0);
    check("rstb_rvalid", obs_rvalid, 1'b0);
    check("rstb_de",     obs_de,     1'b0);
    check("rstb_rdata",  obs_rdata,  8'h00);
    run_req(1'b0, 20'h00101, 2'd0, 8'h00);
    check("rstb_recover_rv", first_rv, 3);
    check("rstb_recover_d",  rd_bytes[0], 8'h22);

    // Zero wait states, then a back-to-back request.
    sel0 = 1'b1;
    run_req(1'b0, 20'h00010, 2'd0, 8'h00);
    check("ws0_first_rv", first_rv, 1);
    check("ws0_done_at",  done_at, 2);
    check("ws0_data",     rd_bytes[0], 8'hA5);
    req = 1'b1; rd_wr = 1'b0; addr = 20'h00101; burst_len = 2'd0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ws0_b2b_rvalid", obs_rvalid, 1'b1);
    check("ws0_b2b_data",   obs_rdata, 8'h22);
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the bus interface unit: accepts the 20-bit physical address and read/write command the unit generates, and answers with bytes on the data path.
- Serves single-byte writes and 1–4 byte sequential read bursts, so one request can fill the 32-bit prefetch queue.
- Inserts programmable wait states and decodes a local address window.
- Used as the far end of the bus in system benches and as an on-chip boot memory.

Parameters:
- ADDR_W, 20, physical address width.
- DEPTH_W, 10, log2 of local byte array size (1024 bytes).
- BASE_ADDR, 20'h00000, window base; must be aligned to 2^DEPTH_W.
- WAIT_STATES, 2, idle cycles between request acceptance and first data (0..15).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- req, input, 1, request strobe; sampled only in IDLE.
- RD_WR, input, 1, command: 1 = write, 0 = read.
- addr, input, ADDR_W, start physical address.
- burst_len, input, 2, read length minus one (0..3 gives 1..4 bytes); ignored for writes.
- wdata, input, 8, write byte.
- busy, output, 1, high from the cycle after acceptance until DONE exits.
- rdata, output, 8, read byte.
- rvalid, output, 1, rdata valid this cycle.
- drive_en, output, 1, output enable for the external data bus buffer; equals rvalid.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, valid with done; start address outside the window.

Behaviour:
- Reset: state = IDLE.
  - busy, rvalid, drive_en, done, err = 0; rdata = 8'h00; counters = 0.
  - Array contents are not cleared.
- States: IDLE, WAIT, XFER, DONE.
- IDLE, on req = 1 at edge k:
  - Latch RD_WR, addr, burst_len and wdata.
  - Compute hit = (addr[ADDR_W-1:DEPTH_W] == BASE_ADDR[ADDR_W-1:DEPTH_W]).
  - Next state: WAIT if WAIT_STATES > 0, else XFER. busy = 1 from k+1.
- WAIT:
  - Count down WAIT_STATES cycles, then go to XFER.
  - A miss also waits, so miss timing matches hit timing.
- XFER, miss: no array access; go straight to DONE with err to be set.
- XFER, write: one cycle. mem[offset] <= latched wdata. rvalid = 0. Then DONE.
- XFER, read:
  - Emits burst_len+1 consecutive cycles with rvalid = drive_en = 1.
  - rdata = mem[offset + i], where i = 0..burst_len.
  - offset arithmetic is modulo 2^DEPTH_W, so the burst wraps inside the window and never leaves it.
  - The first rvalid is registered at edge k+1+WAIT_STATES.
  - Array read is combinational; rdata is registered.
- DONE:
  - One cycle with done = 1 and err = miss; busy = 1 during this cycle.
  - Next state IDLE; busy = 0 from the following cycle.
  - A new req is accepted in that IDLE cycle at the earliest.
- req asserted outside IDLE: ignored, with no queuing.
- Input changes while not in IDLE: no effect, since all inputs are latched.
- reset asserted in any state: next edge returns to IDLE with reset values.
  - A read burst is truncated.
  - A write already in XFER at that edge is still committed; a write in WAIT is dropped.
- rdata holds its last value when rvalid = 0.

Decomposition:
- Shared package mem_resp_pkg holds:
  - state enum {IDLE, WAIT, XFER, DONE};
  - localparams CMD_READ = 0 and CMD_WRITE = 1;
  - the burst length decode function.
- Sub-module mem_byte_array (DEPTH_W parameter):
  - single write port, synchronous write;
  - asynchronous read by offset.
- The FSM, counters and output registers stay in mem_responder.

Test Plan:
- Write then read, WAIT_STATES = 2:
  - Write 8'hA5 at 20'h00010; a 1-byte read of 20'h00010 returns 8'hA5.
  - rvalid rises exactly 3 edges after req is sampled; done follows 1 cycle later; err = 0.
- 4-byte burst:
  - Preload 20'h00100..103 with 11, 22, 33, 44; burst_len = 3.
  - Four consecutive rvalid cycles give 11, 22, 33, 44, with drive_en identical to rvalid.
- Window wrap:
  - Preload offsets 3FE, 3FF, 000 with 5A, 6B, 7C; read 3 bytes from 20'h003FE.
  - Returns 5A, 6B, 7C.
- Miss: read of 20'h40000 with BASE_ADDR = 0 gives no rvalid; done = 1 and err = 1 at edge k+2+WAIT_STATES.
- Reset and ignored requests:
  - Assert reset during the second beat of a 4-byte burst: the next cycle has busy = rvalid = 0 and rdata = 00.
  - A req pulsed during busy produces no extra transaction.
- WAIT_STATES = 0: a 1-byte read gives rvalid at k+1 and done at k+2; a back-to-back req at k+3 is accepted.
